// File: rtl/sw1ton_buf.sv
// Buffered, packet-aware 1-to-N switch.
// One upstream port fans out to OUT_N downstream ports, each with its own
// FIFO. The destination set is taken on the first beat of a packet and held
// until the last beat. Upstream ready depends only on registered FIFO counts,
// so there is no combinational path from dnrdy_i to uprdy_o.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the first beat of a packet (dest from inputs)
// PKT   | mid-packet, beats routed to the latched destination set
// DROP  | mid-packet with a bad destination, beats accepted and discarded

module sw1ton_buf #(
  parameter int OUT_N    = 8,
  parameter int OUT_W    = 3,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 2,
  parameter int MCAST_EN = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        upreq_i,
  input  logic [TAG_W-1:0]            uptag_i,
  input  logic                        uplast_i,
  input  logic [OUT_W-1:0]            up_swb_i,
  input  logic [OUT_N-1:0]            upmask_i,
  output logic                        uprdy_o,
  output logic [OUT_N-1:0]            dnreq_o,
  output logic [OUT_N-1:0][TAG_W-1:0] dntag_o,
  output logic [OUT_N-1:0]            dnlast_o,
  input  logic [OUT_N-1:0]            dnrdy_i,
  output logic                        err_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OUT_W:0] OUT_N_L = OUT_N[OUT_W:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT,
    ST_DROP
  } state_t;

  state_t           state_q;
  logic [OUT_N-1:0] dest_q;
  logic [OUT_N-1:0] cur_mask;
  logic             cur_valid;
  logic [OUT_N-1:0] act_mask;
  logic [OUT_N-1:0] full;
  logic [OUT_N-1:0] push;
  logic             drop_beat;
  logic             fifo_ok;
  logic             accept;

  // Destination set presented by the current beat (used only on first beats).
  always_comb begin
    cur_mask  = '0;
    cur_valid = 1'b0;
    if (MCAST_EN != 0) begin
      cur_mask  = upmask_i;
      cur_valid = |upmask_i;
    end else begin
      cur_valid = ({1'b0, up_swb_i} < OUT_N_L);
      if (cur_valid) begin
        cur_mask = {{(OUT_N-1){1'b0}}, 1'b1} << up_swb_i;
      end
    end
  end

  // Ready / push decision; all-or-none across the destination set.
  always_comb begin
    act_mask  = (state_q == ST_PKT) ? dest_q : cur_mask;
    drop_beat = (state_q == ST_DROP) || ((state_q == ST_IDLE) && !cur_valid);
    fifo_ok   = &(~act_mask | ~full);
    uprdy_o   = rst_ni && (drop_beat || fifo_ok);
    accept    = upreq_i && uprdy_o;
    push      = (accept && !drop_beat) ? act_mask : '0;
  end

  // Packet lock FSM and the registered drop error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= accept && (state_q == ST_IDLE) && !cur_valid;
      case (state_q)
        ST_IDLE: begin
          if (accept && !uplast_i) begin
            if (cur_valid) begin
              state_q <= ST_PKT;
              dest_q  <= cur_mask;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_PKT, ST_DROP: begin
          if (accept && uplast_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < OUT_N; i++) begin : g_fifo
    logic [TAG_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               pop;

    assign pop         = (cnt != '0) && dnrdy_i[i];
    assign full[i]     = (cnt == CNT_W'(DEPTH));
    assign dnreq_o[i]  = (cnt != '0);
    assign dntag_o[i]  = mem[rd_ptr][TAG_W-1:0];
    assign dnlast_o[i] = mem[rd_ptr][TAG_W];

    // Per-output FIFO storage, pointers wrapping modulo DEPTH, and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
        end
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr] <= {uplast_i, uptag_i};
          wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (push[i] && !pop) begin
          cnt <= cnt + CNT_W'(1);
        end else if (!push[i] && pop) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sw1ton_buf.sv
// Directed bench for sw1ton_buf: unicast, packet lock, backpressure, reset,
// drop (6-port instance) and multicast (multicast instance).

module tb_sw1ton_buf;

  logic clk;
  logic rst_n;

  // default unicast instance
  logic             req_a, last_a, rdy_a, err_a;
  logic [3:0]       tag_a;
  logic [2:0]       swb_a;
  logic [7:0]       mask_a, dnreq_a, dnlast_a, dnrdy_a;
  logic [7:0][3:0]  dntag_a;

  // 6-port unicast instance
  logic             req_b, last_b, rdy_b, err_b;
  logic [3:0]       tag_b;
  logic [2:0]       swb_b;
  logic [5:0]       mask_b, dnreq_b, dnlast_b, dnrdy_b;
  logic [5:0][3:0]  dntag_b;

  // multicast instance
  logic             req_c, last_c, rdy_c, err_c;
  logic [3:0]       tag_c;
  logic [2:0]       swb_c;
  logic [7:0]       mask_c, dnreq_c, dnlast_c, dnrdy_c;
  logic [7:0][3:0]  dntag_c;

  int passes = 0;
  int total  = 0;

  sw1ton_buf u_dut (
    .clk_i(clk), .rst_ni(rst_n), .upreq_i(req_a), .uptag_i(tag_a), .uplast_i(last_a),
    .up_swb_i(swb_a), .upmask_i(mask_a), .uprdy_o(rdy_a), .dnreq_o(dnreq_a),
    .dntag_o(dntag_a), .dnlast_o(dnlast_a), .dnrdy_i(dnrdy_a), .err_o(err_a)
  );

  sw1ton_buf #(.OUT_N(6)) u_dut6 (
    .clk_i(clk), .rst_ni(rst_n), .upreq_i(req_b), .uptag_i(tag_b), .uplast_i(last_b),
    .up_swb_i(swb_b), .upmask_i(mask_b), .uprdy_o(rdy_b), .dnreq_o(dnreq_b),
    .dntag_o(dntag_b), .dnlast_o(dnlast_b), .dnrdy_i(dnrdy_b), .err_o(err_b)
  );

  sw1ton_buf #(.MCAST_EN(1)) u_dutm (
    .clk_i(clk), .rst_ni(rst_n), .upreq_i(req_c), .uptag_i(tag_c), .uplast_i(last_c),
    .up_swb_i(swb_c), .upmask_i(mask_c), .uprdy_o(rdy_c), .dnreq_o(dnreq_c),
    .dntag_o(dntag_c), .dnlast_o(dnlast_c), .dnrdy_i(dnrdy_c), .err_o(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 0; last_a = 0; tag_a = 0; swb_a = 0; mask_a = 0; dnrdy_a = 8'hFF;
    req_b = 0; last_b = 0; tag_b = 0; swb_b = 0; mask_b = 0; dnrdy_b = 6'h3F;
    req_c = 0; last_c = 0; tag_c = 0; swb_c = 0; mask_c = 0; dnrdy_c = 8'hFF;
    #2;
    chk("rst_uprdy", 32'(rdy_a), 0);
    chk("rst_dnreq", 32'(dnreq_a), 0);
    chk("rst_dntag", 32'(dntag_a), 0);
    chk("rst_err", 32'(err_a), 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // unicast single beat to port 5
    req_a = 1; swb_a = 3'd5; tag_a = 4'hA; last_a = 1;
    #1;
    chk("uc_uprdy", 32'(rdy_a), 1);
    cyc();
    req_a = 0;
    chk("uc_dnreq", 32'(dnreq_a), 32'h20);
    chk("uc_tag", 32'(dntag_a[5]), 32'hA);
    chk("uc_last", 32'(dnlast_a[5]), 1);
    cyc();
    chk("uc_pulse", 32'(dnreq_a), 0);

    // packet lock: 3 beats to port 2, swb changes ignored
    req_a = 1; swb_a = 3'd2; tag_a = 4'h1; last_a = 0;
    cyc();
    chk("lock_b1_req", 32'(dnreq_a), 32'h04);
    chk("lock_b1_tag", 32'(dntag_a[2]), 1);
    swb_a = 3'd6; tag_a = 4'h2;
    cyc();
    chk("lock_b2_req", 32'(dnreq_a), 32'h04);
    chk("lock_b2_tag", 32'(dntag_a[2]), 2);
    tag_a = 4'h3; last_a = 1;
    cyc();
    req_a = 0;
    chk("lock_b3_req", 32'(dnreq_a), 32'h04);
    chk("lock_b3_tag", 32'(dntag_a[2]), 3);
    chk("lock_b3_last", 32'(dnlast_a[2]), 1);
    cyc();
    chk("lock_end", 32'(dnreq_a), 0);

    // backpressure on port 3
    dnrdy_a = 8'hF7;
    req_a = 1; swb_a = 3'd3; tag_a = 4'h4; last_a = 1;
    #1;
    chk("bp_rdy1", 32'(rdy_a), 1);
    cyc();
    tag_a = 4'h5;
    #1;
    chk("bp_rdy2", 32'(rdy_a), 1);
    cyc();
    tag_a = 4'h6;
    #1;
    chk("bp_full_rdy", 32'(rdy_a), 0);
    chk("bp_full_req", 32'(dnreq_a), 32'h08);
    chk("bp_head", 32'(dntag_a[3]), 4);
    cyc();
    chk("bp_hold_rdy", 32'(rdy_a), 0);
    dnrdy_a = 8'hFF;
    #1;
    chk("bp_no_comb", 32'(rdy_a), 0);
    cyc();
    chk("bp_rel_rdy", 32'(rdy_a), 1);
    chk("bp_rel_head", 32'(dntag_a[3]), 5);
    cyc();
    req_a = 0;
    chk("bp_drain_head", 32'(dntag_a[3]), 6);
    cyc();
    chk("bp_empty", 32'(dnreq_a), 0);

    // reset mid-packet, then new destination
    dnrdy_a = 8'h00;
    req_a = 1; swb_a = 3'd1; tag_a = 4'h7; last_a = 0;
    cyc();
    req_a = 0;
    chk("mr_held", 32'(dnreq_a), 32'h02);
    rst_n = 1'b0;
    #1;
    chk("mr_dnreq", 32'(dnreq_a), 0);
    chk("mr_uprdy", 32'(rdy_a), 0);
    #1;
    rst_n = 1'b1;
    req_a = 1; swb_a = 3'd4; tag_a = 4'h8; last_a = 1;
    #1;
    chk("mr_rdy", 32'(rdy_a), 1);
    cyc();
    req_a = 0;
    chk("mr_route", 32'(dnreq_a), 32'h10);
    chk("mr_tag", 32'(dntag_a[4]), 8);

    // drop on 6-port instance
    req_b = 1; swb_b = 3'd7; tag_b = 4'h1; last_b = 0;
    #1;
    chk("drop_rdy1", 32'(rdy_b), 1);
    cyc();
    chk("drop_err1", 32'(err_b), 1);
    chk("drop_req1", 32'(dnreq_b), 0);
    swb_b = 3'd0; tag_b = 4'h2; last_b = 1;
    #1;
    chk("drop_rdy2", 32'(rdy_b), 1);
    cyc();
    req_b = 0;
    chk("drop_err2", 32'(err_b), 0);
    chk("drop_req2", 32'(dnreq_b), 0);
    cyc();
    chk("drop_err3", 32'(err_b), 0);
    req_b = 1; swb_b = 3'd0; tag_b = 4'h3; last_b = 1;
    cyc();
    req_b = 0;
    chk("drop_after", 32'(dnreq_b), 32'h01);

    // multicast with port 4 full
    dnrdy_c = 8'hEF;
    req_c = 1; mask_c = 8'h10; tag_c = 4'h1; last_c = 1;
    cyc();
    tag_c = 4'h2;
    cyc();
    mask_c = 8'h91; tag_c = 4'h9;
    #1;
    chk("mc_blocked", 32'(rdy_c), 0);
    cyc();
    chk("mc_none", 32'(dnreq_c), 32'h10);
    dnrdy_c = 8'hFF;
    cyc();
    chk("mc_rdy", 32'(rdy_c), 1);
    cyc();
    req_c = 0;
    chk("mc_req", 32'(dnreq_c), 32'h91);
    chk("mc_t0", 32'(dntag_c[0]), 9);
    chk("mc_t4", 32'(dntag_c[4]), 9);
    chk("mc_t7", 32'(dntag_c[7]), 9);
    req_c = 1; mask_c = 8'h00; tag_c = 4'hF; last_c = 1;
    #1;
    chk("mc_zero_rdy", 32'(rdy_c), 1);
    cyc();
    req_c = 0;
    chk("mc_zero_err", 32'(err_c), 1);
    chk("mc_zero_req", 32'(dnreq_c), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
